// File: rtl/pgm_pkg.sv
// Shared sound-mailbox constants: Z80 I/O port map and status register bit positions.
package pgm_pkg;

   localparam logic [7:0] PORT_LO   = 8'h00;
   localparam logic [7:0] PORT_HI   = 8'h01;
   localparam logic [7:0] PORT_STAT = 8'h02;

   localparam int STAT_NONEMPTY = 0;
   localparam int STAT_FULL     = 1;
   localparam int STAT_OVF      = 2;

   function automatic logic is_mbox_port(input logic [7:0] port);
      return (port == PORT_LO) || (port == PORT_HI) || (port == PORT_STAT);
   endfunction

endpackage

// File: rtl/pgm_tgl_sync.sv
// Toggle-to-event crossing: 2-FF synchronizer plus edge register, one event per level change.
module pgm_tgl_sync (
   input  logic fixed_8m_clk,
   input  logic i_tgl,
   output logic o_event
);

   // Deliberately unreset so the chain follows the input level through reset.
   logic [2:0] r_sync;

   always_ff @(posedge fixed_8m_clk)
      r_sync <= {r_sync[1:0], i_tgl};

   assign o_event = r_sync[2] ^ r_sync[1];

endmodule

// File: rtl/pgm_sound_mailbox.sv
// 68k <-> Z80 sound mailbox. Define PGM_SNDMBOX_FIFO_EN for a 2^DEPTH_LOG2-entry
// command FIFO; otherwise commands go through a single overwrite latch.
module pgm_sound_mailbox
   import pgm_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic        fixed_8m_clk,
   input  logic        reset,
   input  logic        m68k_wr_tgl,
   input  logic [15:0] m68k_wr_data,
   input  logic        m68k_rd_ack_tgl,
   output logic [15:0] m68k_rd_data,
   output logic        m68k_rd_valid,
   input  logic [7:0]  z_port,
   input  logic [7:0]  z_din,
   input  logic        z_iorq_n,
   input  logic        z_rd_n,
   input  logic        z_wr_n,
   output logic [7:0]  z_dout,
   output logic        z_dout_en,
   output logic        z_int_n
);

   logic        w_wr_evt, w_ack_evt;
   logic        w_io_act, w_io_stb, w_rd_stb, w_wr_stb;
   logic        w_pop, w_ovf_set, w_nonempty, w_full;
   logic [15:0] w_head;
   logic [7:0]  w_status;
   logic        r_io_prev, r_ovf, r_rd_valid;
   logic [15:0] r_reply;

   pgm_tgl_sync u_wr_sync  (.fixed_8m_clk(fixed_8m_clk), .i_tgl(m68k_wr_tgl),     .o_event(w_wr_evt));
   pgm_tgl_sync u_ack_sync (.fixed_8m_clk(fixed_8m_clk), .i_tgl(m68k_rd_ack_tgl), .o_event(w_ack_evt));

   // Act once per Z80 I/O cycle, on the first clock the strobe is seen.
   assign w_io_act = !z_iorq_n && (!z_rd_n || !z_wr_n);
   assign w_io_stb = w_io_act && !r_io_prev;
   assign w_rd_stb = w_io_stb && !z_rd_n;
   assign w_wr_stb = w_io_stb && z_rd_n && !z_wr_n;
   assign w_pop    = w_rd_stb && (z_port == PORT_HI) && w_nonempty;

`ifdef PGM_SNDMBOX_FIFO_EN
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [15:0]           r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_push_ok;

   assign w_nonempty = (r_count != '0);
   assign w_full     = (r_count == (DEPTH_LOG2+1)'(DEPTH));
   assign w_push_ok  = w_wr_evt && (!w_full || w_pop);
   assign w_ovf_set  = w_wr_evt && w_full && !w_pop;
   assign w_head     = w_nonempty ? r_mem[r_rd_ptr] : 16'hFFFF;

   always_ff @(posedge fixed_8m_clk)
      if (!reset && w_push_ok)
         r_mem[r_wr_ptr] <= m68k_wr_data;

   always_ff @(posedge fixed_8m_clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
            2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
`else
   logic [15:0] r_latch;
   logic        r_valid;
   logic        w_unused;

   assign w_unused   = (DEPTH_LOG2 > 0);
   assign w_nonempty = r_valid;
   assign w_full     = r_valid;
   assign w_ovf_set  = w_wr_evt && r_valid && !w_pop;
   assign w_head     = r_valid ? r_latch : 16'hFFFF;

   always_ff @(posedge fixed_8m_clk)
      if (!reset && w_wr_evt)
         r_latch <= m68k_wr_data;

   always_ff @(posedge fixed_8m_clk) begin
      if (reset)         r_valid <= 1'b0;
      else if (w_wr_evt) r_valid <= 1'b1;
      else if (w_pop)    r_valid <= 1'b0;
   end
`endif

   // A new overflow in the same clock as a status read stays visible.
   always_ff @(posedge fixed_8m_clk) begin
      if (reset) begin
         r_io_prev  <= 1'b0;
         r_ovf      <= 1'b0;
         r_reply    <= 16'h0000;
         r_rd_valid <= 1'b0;
      end else begin
         r_io_prev <= w_io_act;
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (w_rd_stb && (z_port == PORT_STAT))
            r_ovf <= 1'b0;
         if (w_wr_stb && (z_port == PORT_LO)) r_reply[7:0]  <= z_din;
         if (w_wr_stb && (z_port == PORT_HI)) r_reply[15:8] <= z_din;
         if (w_wr_stb && (z_port == PORT_HI))
            r_rd_valid <= 1'b1;
         else if (w_ack_evt)
            r_rd_valid <= 1'b0;
      end
   end

   always_comb begin
      w_status                = 8'h00;
      w_status[STAT_NONEMPTY] = w_nonempty;
      w_status[STAT_FULL]     = w_full;
      w_status[STAT_OVF]      = r_ovf;
   end

   always_comb begin
      z_dout    = 8'hFF;
      z_dout_en = !z_iorq_n && !z_rd_n && is_mbox_port(z_port);
      if (z_dout_en) begin
         case (z_port)
            PORT_LO: z_dout = w_head[7:0];
            PORT_HI: z_dout = w_head[15:8];
            default: z_dout = w_status;
         endcase
      end
   end

   assign m68k_rd_data  = r_reply;
   assign m68k_rd_valid = r_rd_valid;
   assign z_int_n       = !w_nonempty;

endmodule

// File: tb/tb_pgm_sound_mailbox.sv
// Self-checking bench for pgm_sound_mailbox: vector table, corner sequences, random ops vs queue model.
module tb_pgm_sound_mailbox;

`ifdef PGM_SNDMBOX_FIFO_EN
   localparam bit FIFO = 1'b1;
   localparam int CAP  = 4;
`else
   localparam bit FIFO = 1'b0;
   localparam int CAP  = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_tgl, ack_tgl;
   logic [15:0] wr_data;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [7:0]  z_port, z_din, z_dout;
   logic        z_iorq_n, z_rd_n, z_wr_n, z_dout_en, z_int_n;

   always #5 clk = ~clk;

   pgm_sound_mailbox #(.DEPTH_LOG2(2)) dut (
      .fixed_8m_clk(clk), .reset(reset),
      .m68k_wr_tgl(wr_tgl), .m68k_wr_data(wr_data), .m68k_rd_ack_tgl(ack_tgl),
      .m68k_rd_data(rd_data), .m68k_rd_valid(rd_valid),
      .z_port(z_port), .z_din(z_din), .z_iorq_n(z_iorq_n), .z_rd_n(z_rd_n), .z_wr_n(z_wr_n),
      .z_dout(z_dout), .z_dout_en(z_dout_en), .z_int_n(z_int_n)
   );

   int errs = 0, checks = 0;

   // Reference model: command queue, sticky overflow, reply word and its valid flag.
   logic [15:0] mq[$];
   bit          movf, mvalid;
   logic [15:0] mreply;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mhead();
      return (mq.size() != 0) ? mq[0] : 16'hFFFF;
   endfunction

   function automatic logic [7:0] mstat();
      return {5'b0, movf, mq.size() == CAP, mq.size() != 0};
   endfunction

   function automatic logic [7:0] mread(input logic [7:0] p);
      logic [15:0] h;
      h = mhead();
      case (p)
         8'h00:   return h[7:0];
         8'h01:   return h[15:8];
         8'h02:   return mstat();
         default: return 8'hFF;
      endcase
   endfunction

   task automatic model_push(input logic [15:0] d);
      if (mq.size() < CAP) mq.push_back(d);
      else begin
         movf = 1'b1;
         if (!FIFO) mq[0] = d;
      end
   endtask

   task automatic model_pop();
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "/int_n"}, z_int_n, mq.size() == 0);
      chk({tag, "/rd_valid"}, rd_valid, mvalid);
      chk({tag, "/rd_data"}, rd_data, mreply);
   endtask

   task automatic m_write(input logic [15:0] d);
      wr_data = d;
      wr_tgl  = ~wr_tgl;
      tick(); tick();
      chk("wr_latency", z_int_n, mq.size() == 0);
      tick();
      model_push(d);
      check_outs("m_write");
   endtask

   task automatic m_ack();
      ack_tgl = ~ack_tgl;
      tick(); tick();
      chk("ack_latency", rd_valid, mvalid);
      tick();
      mvalid = 1'b0;
      check_outs("m_ack");
   endtask

   task automatic z_in(input logic [7:0] p, output logic [7:0] got);
      z_port = p; z_iorq_n = 1'b0; z_rd_n = 1'b0;
      #1;
      got = z_dout;
      chk("z_in/dout", z_dout, mread(p));
      chk("z_in/en", z_dout_en, p <= 8'h02);
      tick();
      z_iorq_n = 1'b1; z_rd_n = 1'b1;
      tick();
      if (p == 8'h01) model_pop();
      if (p == 8'h02) movf = 1'b0;
      check_outs("z_in");
   endtask

   task automatic z_out(input logic [7:0] p, input logic [7:0] d);
      z_port = p; z_din = d; z_iorq_n = 1'b0; z_wr_n = 1'b0;
      #1;
      chk("z_out/en", z_dout_en, 1'b0);
      tick();
      z_iorq_n = 1'b1; z_wr_n = 1'b1;
      tick();
      if (p == 8'h00) mreply[7:0] = d;
      if (p == 8'h01) begin mreply[15:8] = d; mvalid = 1'b1; end
      check_outs("z_out");
   endtask

   typedef enum {OP_W, OP_IN, OP_OUT, OP_ACK, OP_RPY} op_e;
   typedef struct {
      op_e         op;
      logic [7:0]  port;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [7:0]  got;
   logic [15:0] rv;

   initial begin
      reset = 1'b1; wr_tgl = 1'b0; ack_tgl = 1'b0; wr_data = '0;
      z_port = '0; z_din = '0; z_iorq_n = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1;
      movf = 1'b0; mvalid = 1'b0; mreply = '0;
      repeat (4) tick();
      chk("rst/int_n", z_int_n, 1'b1);
      chk("rst/rd_valid", rd_valid, 1'b0);
      chk("rst/rd_data", rd_data, 16'h0000);
      chk("rst/dout", z_dout, 8'hFF);
      chk("rst/dout_en", z_dout_en, 1'b0);
      reset = 1'b0;
      tick();

      // Fixed vectors: basic command path, reply path, unmapped ports, empty head.
      tbl.push_back('{OP_W,   8'h00, 16'h1234, 16'h0000});
      tbl.push_back('{OP_IN,  8'h00, 16'h0000, 16'h0034});
      tbl.push_back('{OP_IN,  8'h01, 16'h0000, 16'h0012});
      tbl.push_back('{OP_IN,  8'h02, 16'h0000, 16'h0000});
      tbl.push_back('{OP_IN,  8'h05, 16'h0000, 16'h00FF});
      tbl.push_back('{OP_OUT, 8'h00, 16'h00CD, 16'h0000});
      tbl.push_back('{OP_OUT, 8'h01, 16'h00AB, 16'h0000});
      tbl.push_back('{OP_RPY, 8'h00, 16'h0000, 16'hABCD});
      tbl.push_back('{OP_ACK, 8'h00, 16'h0000, 16'h0000});
      tbl.push_back('{OP_OUT, 8'h07, 16'h0099, 16'h0000});
      tbl.push_back('{OP_RPY, 8'h00, 16'h0000, 16'hABCD});
      tbl.push_back('{OP_IN,  8'h00, 16'h0000, 16'h00FF});
      tbl.push_back('{OP_IN,  8'h01, 16'h0000, 16'h00FF});
      tbl.push_back('{OP_IN,  8'h02, 16'h0000, 16'h0000});
`ifdef PGM_SNDMBOX_FIFO_EN
      for (int i = 1; i <= 5; i++) tbl.push_back('{OP_W, 8'h00, 16'hA000 + 16'(i), 16'h0000});
      tbl.push_back('{OP_IN, 8'h02, 16'h0000, 16'h0007});
      tbl.push_back('{OP_IN, 8'h02, 16'h0000, 16'h0003});
      for (int i = 1; i <= 4; i++) begin
         tbl.push_back('{OP_IN, 8'h00, 16'h0000, 16'(i)});
         tbl.push_back('{OP_IN, 8'h01, 16'h0000, 16'h00A0});
      end
`else
      tbl.push_back('{OP_W,  8'h00, 16'hA001, 16'h0000});
      tbl.push_back('{OP_W,  8'h00, 16'hA002, 16'h0000});
      tbl.push_back('{OP_IN, 8'h02, 16'h0000, 16'h0007});
      tbl.push_back('{OP_IN, 8'h02, 16'h0000, 16'h0003});
      tbl.push_back('{OP_IN, 8'h00, 16'h0000, 16'h0002});
      tbl.push_back('{OP_IN, 8'h01, 16'h0000, 16'h00A0});
`endif
      tbl.push_back('{OP_IN, 8'h02, 16'h0000, 16'h0000});

      foreach (tbl[i]) begin
         case (tbl[i].op)
            OP_W:   m_write(tbl[i].data);
            OP_IN:  begin z_in(tbl[i].port, got); chk($sformatf("vec%0d/in", i), got, tbl[i].exp[7:0]); end
            OP_OUT: z_out(tbl[i].port, tbl[i].data[7:0]);
            OP_ACK: m_ack();
            OP_RPY: chk($sformatf("vec%0d/reply", i), rd_data, tbl[i].exp);
            default: ;
         endcase
      end

      // Held IN 0x01 pops once; a push landing mid-hold must survive.
      m_write(16'hB001);
      if (FIFO) m_write(16'hB002);
      wr_data = 16'hC003; wr_tgl = ~wr_tgl;
      z_port = 8'h01; z_iorq_n = 1'b0; z_rd_n = 1'b0;
      repeat (4) tick();
      z_iorq_n = 1'b1; z_rd_n = 1'b1;
      tick();
      model_pop(); model_push(16'hC003);
      check_outs("hold");
      z_in(8'h02, got);

      // Push and pop in the same clock (queue full in latch mode, count 2 in FIFO mode).
      wr_data = 16'hD004; wr_tgl = ~wr_tgl;
      tick(); tick();
      z_port = 8'h01; z_iorq_n = 1'b0; z_rd_n = 1'b0;
      tick();
      z_iorq_n = 1'b1; z_rd_n = 1'b1;
      tick();
      model_pop(); model_push(16'hD004);
      check_outs("push_pop");
      z_in(8'h02, got);
      chk("push_pop/no_ovf", got[2], 1'b0);
      while (mq.size() != 0) begin z_in(8'h00, got); z_in(8'h01, got); end

`ifdef PGM_SNDMBOX_FIFO_EN
      for (int i = 0; i < 4; i++) m_write(16'hE100 + 16'(i));
      wr_data = 16'hE1FF; wr_tgl = ~wr_tgl;
      tick(); tick();
      z_port = 8'h01; z_iorq_n = 1'b0; z_rd_n = 1'b0;
      tick();
      z_iorq_n = 1'b1; z_rd_n = 1'b1;
      tick();
      model_pop(); model_push(16'hE1FF);
      z_in(8'h02, got);
      chk("full_push_pop/status", got, 8'h03);
      while (mq.size() != 0) begin z_in(8'h00, got); z_in(8'h01, got); end
`endif

      // Ack event and Z80 high-byte write in the same clock: valid ends set.
      z_out(8'h00, 8'h11);
      ack_tgl = ~ack_tgl;
      tick(); tick();
      z_port = 8'h01; z_din = 8'h22; z_iorq_n = 1'b0; z_wr_n = 1'b0;
      tick();
      z_iorq_n = 1'b1; z_wr_n = 1'b1;
      tick();
      mreply = 16'h2211; mvalid = 1'b1;
      check_outs("ack_vs_wr");

      // Reset with a pending word and the write toggle rising during reset.
      m_write(16'hE005);
      reset = 1'b1;
      wr_tgl = 1'b0; tick(); tick();
      wr_tgl = 1'b1;
      repeat (5) tick();
      reset = 1'b0;
      mq.delete(); movf = 1'b0; mreply = '0; mvalid = 1'b0;
      repeat (5) tick();
      check_outs("after_reset");
      z_in(8'h02, got);
      chk("after_reset/status", got, 8'h00);

      // Randomized operations against the model.
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: m_write(16'($urandom));
            3, 4:    z_in(8'($urandom_range(0, 3)), got);
            5:       z_in(8'h01, got);
            6:       z_in(8'h02, got);
            7:       z_out(8'($urandom_range(0, 2)), 8'($urandom));
            8:       m_ack();
            default: z_out(8'h01, 8'($urandom));
         endcase
      end
      while (mq.size() != 0) begin
         z_in(8'h00, got);
         z_in(8'h01, got);
      end
      rv = {8'h00, 8'h00};
      z_in(8'h00, got);
      chk("drained/head", got, rv[7:0] | 8'hFF);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
